// File: rtl/gpu_sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds and show-ahead or registered read.
// Define FIFO_STICKY_ERR_EN to add sticky overflow/underflow flags with an err_clr input.
module gpu_sync_fifo #(
   parameter int WIDTH        = 32,
   parameter int DEPTH_LOG2   = 4,
   parameter int SHOWAHEAD    = 1,
   parameter int AFULL_LEVEL  = (2 ** DEPTH_LOG2) - 2,
   parameter int AEMPTY_LEVEL = 2
) (
   input  logic                  clock,
   input  logic                  aclr_n,
   input  logic                  sclr,
   input  logic [WIDTH-1:0]      data,
   input  logic                  wrreq,
   input  logic                  rdreq,
   output logic [WIDTH-1:0]      q,
   output logic [DEPTH_LOG2:0]   usedw,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
`ifdef FIFO_STICKY_ERR_EN
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
`else
   output logic                  almost_empty
`endif
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_LEVEL);
   localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_LEVEL);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]         count;
   logic                  valid_wr;
   logic                  valid_rd;

   // A write while full only goes through when a read frees a slot in the same cycle.
   assign valid_rd = rdreq & ~empty;
   assign valid_wr = wrreq & (~full | rdreq);

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (sclr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (valid_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (valid_rd)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(valid_wr) - CW'(valid_rd);
      end
   end

   always_ff @(posedge clock) begin
      if (valid_wr && !sclr)
         mem[wr_ptr] <= data;
   end

   assign usedw        = count;
   assign full         = (count == DEPTH_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_CNT);
   assign almost_empty = (count <= AEMPTY_CNT);

   // Show-ahead output is forced to zero while empty so reset/clear leave q at a known value.
   if (SHOWAHEAD != 0) begin : g_showahead
      assign q = empty ? '0 : mem[rd_ptr];
   end else begin : g_normal
      always_ff @(posedge clock or negedge aclr_n) begin
         if (!aclr_n)
            q <= '0;
         else if (sclr)
            q <= '0;
         else if (valid_rd)
            q <= mem[rd_ptr];
      end
   end

`ifdef FIFO_STICKY_ERR_EN
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wrreq & full & ~rdreq)
            overflow <= 1'b1;
         else if (err_clr)
            overflow <= 1'b0;
         if (rdreq & empty)
            underflow <= 1'b1;
         else if (err_clr)
            underflow <= 1'b0;
      end
   end
`endif

   if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
      $error("gpu_sync_fifo: AFULL_LEVEL out of range 1..DEPTH");
   end
   if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
      $error("gpu_sync_fifo: AEMPTY_LEVEL out of range 0..DEPTH-1");
   end

endmodule
